// File: rtl/gold_seq_ctrl_if.sv
// Request and generator buses shared between the Gold-code sequencer and its peers.
// The slave side is the sequencer; the master side is the requesters plus the generator.
interface gold_seq_ctrl_if #(
    parameter int N_REQ  = 4,
    parameter int LENGTH = 6
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*LENGTH-1:0] req_seed1;
    logic [N_REQ*LENGTH-1:0] req_seed2;
    logic [N_REQ*8-1:0]      req_periods;
    logic                    gen_load;
    logic [LENGTH-1:0]       gen_seed1;
    logic [LENGTH-1:0]       gen_seed2;
    logic                    gen_en;
    logic                    gen_strobe;

    modport master (
        output req_valid, req_seed1, req_seed2, req_periods, gen_strobe,
        input  req_ready, gen_load, gen_seed1, gen_seed2, gen_en
    );

    modport slave (
        input  req_valid, req_seed1, req_seed2, req_periods, gen_strobe,
        output req_ready, gen_load, gen_seed1, gen_seed2, gen_en
    );
endinterface

// File: rtl/gold_seq_ctrl.sv
// Round-robin job sequencer that hands one Gold-code generator to N_REQ requesters,
// loading seeds, waiting HOLD settle cycles and running for a set number of code periods.
module gold_seq_ctrl #(
    parameter int N_REQ  = 4,
    parameter int LENGTH = 6,
    parameter int N      = 63,
    parameter int HOLD   = 3
) (
    input  logic                  clkin,
    input  logic                  rstn,
    gold_seq_ctrl_if.slave        bus,
    input  logic                  abort_i,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] done_id,
    output logic                  err_o,
    output logic                  sync_err
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, LOAD, SETTLE, RUN, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_last;
    logic [LENGTH-1:0] r_seed1;
    logic [LENGTH-1:0] r_seed2;
    logic [7:0]        r_periods;
    logic [CW-1:0]     r_chipCnt;
    logic [7:0]        r_periodCnt;
    logic [HW-1:0]     r_holdCnt;
    logic              r_err;
    logic              r_sync;

    logic [LENGTH-1:0] w_seed1 [N_REQ];
    logic [LENGTH-1:0] w_seed2 [N_REQ];
    logic [7:0]        w_periods [N_REQ];
    logic [IW-1:0]     w_pick;
    logic [IW-1:0]     w_cand;
    logic              w_zeroSeed;
    logic              w_zeroPer;
    logic              w_lastChip;
    logic              w_lastPer;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign w_seed1[gi]   = bus.req_seed1[gi*LENGTH +: LENGTH];
        assign w_seed2[gi]   = bus.req_seed2[gi*LENGTH +: LENGTH];
        assign w_periods[gi] = bus.req_periods[gi*8 +: 8];
    end

    // Scanning from farthest to nearest leaves the requester closest after r_last in w_pick.
    always_comb begin
        w_pick = r_last;
        w_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = IW'((int'(r_last) + k) % N_REQ);
            if (bus.req_valid[w_cand]) w_pick = w_cand;
        end
    end

    assign w_zeroSeed = (w_seed1[r_owner] == '0) || (w_seed2[r_owner] == '0);
    assign w_zeroPer  = (w_periods[r_owner] == 8'd0);
    assign w_lastChip = (r_chipCnt == CW'(N - 1));
    assign w_lastPer  = (r_periodCnt == r_periods - 8'd1);

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|bus.req_valid) w_next = GRANT;
            GRANT:   w_next = (w_zeroSeed || w_zeroPer) ? DONE : LOAD;
            LOAD:    w_next = abort_i ? DONE : ((HOLD == 0) ? RUN : SETTLE);
            SETTLE:  if (abort_i) w_next = DONE;
                     else if (r_holdCnt == HW'(HOLD - 1)) w_next = RUN;
            RUN:     if (abort_i || (w_lastChip && w_lastPer)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Seeds and limits come straight from the requester during GRANT, while its data is held stable.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_owner     <= '0;
            r_last      <= IW'(N_REQ - 1);
            r_seed1     <= '0;
            r_seed2     <= '0;
            r_periods   <= '0;
            r_chipCnt   <= '0;
            r_periodCnt <= '0;
            r_holdCnt   <= '0;
            r_err       <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_next == GRANT) r_owner <= w_pick;
                GRANT: begin
                    r_seed1   <= w_seed1[r_owner];
                    r_seed2   <= w_seed2[r_owner];
                    r_periods <= w_periods[r_owner];
                    r_err     <= w_zeroSeed;
                end
                LOAD: begin
                    r_sync      <= 1'b0;
                    r_holdCnt   <= '0;
                    r_chipCnt   <= '0;
                    r_periodCnt <= '0;
                    if (abort_i) r_err <= 1'b1;
                end
                SETTLE: begin
                    r_holdCnt <= r_holdCnt + 1'b1;
                    if (abort_i) r_err <= 1'b1;
                end
                RUN: begin
                    if (abort_i) r_err <= 1'b1;
                    if (bus.gen_strobe != w_lastChip) r_sync <= 1'b1;
                    r_chipCnt <= w_lastChip ? '0 : r_chipCnt + 1'b1;
                    if (w_lastChip) r_periodCnt <= r_periodCnt + 8'd1;
                end
                DONE: r_last <= r_owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.gen_load  = 1'b0;
        bus.gen_seed1 = '0;
        bus.gen_seed2 = '0;
        bus.gen_en    = 1'b0;
        done_o        = 1'b0;
        done_id       = '0;
        err_o         = 1'b0;
        busy_o        = (r_state != IDLE);
        owner_o       = r_owner;
        sync_err      = r_sync;
        case (r_state)
            GRANT: bus.req_ready = N_REQ'(1) << r_owner;
            LOAD: begin
                bus.gen_load  = 1'b1;
                bus.gen_seed1 = r_seed1;
                bus.gen_seed2 = r_seed2;
            end
            RUN:  bus.gen_en = 1'b1;
            DONE: begin
                done_o  = 1'b1;
                done_id = r_owner;
                err_o   = r_err;
            end
            default: ;
        endcase
    end
endmodule
